// File: rtl/cpu_multicycle_core_if.sv
// Fetch and data-memory bus of the multi-cycle core.
// The core is the master: it drives the fetch handshake and the memory strobes.
interface cpu_multicycle_core_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int ADDR_W     = 16
);
    localparam int INSTR_W = 4 + 3*REG_ADDR_W + 3;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  data_in;
    logic [DATA_W-1:0]  data_out;
    logic [ADDR_W-1:0]  address;
    logic               mem_read;
    logic               mem_write;
    logic               mem_ready;

    modport master (
        input  instr, instr_valid, data_in, mem_ready,
        output instr_ready, pc, data_out, address, mem_read, mem_write
    );

    modport slave (
        output instr, instr_valid, data_in, mem_ready,
        input  instr_ready, pc, data_out, address, mem_read, mem_write
    );
endinterface

// File: rtl/cpu_multicycle_core.sv
// Multi-cycle register CPU: FETCH -> EXEC (-> MEM) with a ready-stalled data port,
// sticky divide-by-zero flag, retire pulse and a combinational debug register read.
module cpu_multicycle_core #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cpu_multicycle_core_if.master bus,
    output logic                  retire,
    output logic                  div_zero,
    input  logic [REG_ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]     dbg_data
);
    localparam int INSTR_W = 4 + 3*REG_ADDR_W + 3;
    localparam int NREGS   = 2**REG_ADDR_W;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL  = 4'd2,  OP_DIV  = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4,  OP_DEC = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8,  OP_NOT = 4'd9,  OP_LOAD = 4'd10, OP_STORE = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12, OP_BEQ = 4'd13, OP_BNE  = 4'd14, OP_CALL = 4'd15;

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

    state_t                state_q, state_d;
    logic [INSTR_W-1:0]    ir;
    logic [ADDR_W-1:0]     pc_q;
    logic [DATA_W-1:0]     regs [NREGS];

    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] ra, rb, rc;
    logic [DATA_W-1:0]     va, vb, vc;
    logic [ADDR_W-1:0]     pc_inc, jmp_tgt, br_tgt;
    logic                  is_mem;

    assign op      = ir[INSTR_W-1 -: 4];
    assign ra      = ir[INSTR_W-5 -: REG_ADDR_W];
    assign rb      = ir[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
    assign rc      = ir[REG_ADDR_W+2:3];
    assign va      = regs[ra];
    assign vb      = regs[rb];
    assign vc      = regs[rc];
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign jmp_tgt = ADDR_W'(ir[INSTR_W-5:0]);
    assign br_tgt  = ADDR_W'(ir[6:0]);
    assign is_mem  = (op == OP_LOAD) || (op == OP_STORE);

    assign dbg_data = regs[dbg_sel];

    // Execute-stage result, write target and next PC for non-memory ops
    logic [DATA_W-1:0]     res;
    logic [REG_ADDR_W-1:0] wr_idx;
    logic                  wr_en, set_dz;
    logic [ADDR_W-1:0]     pc_next;

    always_comb begin
        res     = '0;
        wr_idx  = ra;
        wr_en   = 1'b0;
        set_dz  = 1'b0;
        pc_next = pc_inc;
        case (op)
            OP_ADD: begin res = vb + vc; wr_en = 1'b1; end
            OP_SUB: begin res = vb - vc; wr_en = 1'b1; end
            OP_MUL: begin res = vb * vc; wr_en = 1'b1; end
            OP_DIV: begin
                wr_en = 1'b1;
                if (vc == '0) begin
                    res    = '1;
                    set_dz = 1'b1;
                end else begin
                    res = vb / vc;
                end
            end
            OP_INC: begin res = va + DATA_W'(1); wr_en = 1'b1; end
            OP_DEC: begin res = va - DATA_W'(1); wr_en = 1'b1; end
            OP_AND: begin res = vb & vc; wr_en = 1'b1; end
            OP_OR:  begin res = vb | vc; wr_en = 1'b1; end
            OP_XOR: begin res = vb ^ vc; wr_en = 1'b1; end
            OP_NOT: begin res = ~vb; wr_en = 1'b1; end
            OP_JMP: pc_next = jmp_tgt;
            OP_BEQ: pc_next = (va == vb) ? br_tgt : pc_inc;
            OP_BNE: pc_next = (va != vb) ? br_tgt : pc_inc;
            OP_CALL: begin
                // CALL only ever writes the link register, regardless of A
                wr_idx  = '1;
                res     = DATA_W'(pc_inc);
                wr_en   = 1'b1;
                pc_next = jmp_tgt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (bus.instr_valid) state_d = EXEC;
            EXEC:    state_d = is_mem ? MEM : FETCH;
            MEM:     if (bus.mem_ready) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Bus outputs decode from the async-reset state, so strobes drop the moment reset asserts
    assign bus.instr_ready = reset_n && (state_q == FETCH);
    assign bus.pc          = pc_q;
    assign bus.mem_read    = (state_q == MEM) && (op == OP_LOAD);
    assign bus.mem_write   = (state_q == MEM) && (op == OP_STORE);
    assign bus.address     = (state_q == MEM) ? ADDR_W'(vb) : '0;
    assign bus.data_out    = bus.mem_write ? vc : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= '0;
            pc_q     <= '0;
            retire   <= 1'b0;
            div_zero <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state_q)
                FETCH: if (bus.instr_valid) ir <= bus.instr;
                EXEC: if (!is_mem) begin
                    if (wr_en)  regs[wr_idx] <= res;
                    if (set_dz) div_zero <= 1'b1;
                    pc_q   <= pc_next;
                    retire <= 1'b1;
                end
                MEM: if (bus.mem_ready) begin
                    if (op == OP_LOAD) regs[ra] <= bus.data_in;
                    pc_q   <= pc_inc;
                    retire <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multicycle_core.sv
// Directed bench: a 16-bit core and a 32-bit/32-register core, driven from one vector table
// format, plus hand-written LOAD/STORE wait-state and mid-access reset sequences.
module tb_cpu_multicycle_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic [21:0] ins_w = '0;
    logic        valid_w = 1'b0, ready_w = 1'b0;
    logic [31:0] rdata_w = '0;
    logic [4:0]  dsel = '0;
    int          n_vec = 0, n_err = 0, cur_idx = 0;

    always #5 clk = ~clk;

    cpu_multicycle_core_if #(.DATA_W(16), .REG_ADDR_W(4), .ADDR_W(16)) b0 ();
    cpu_multicycle_core_if #(.DATA_W(32), .REG_ADDR_W(5), .ADDR_W(16)) b1 ();

    assign b0.instr       = ins_w[18:0];
    assign b0.instr_valid = valid_w & ~sel;
    assign b0.mem_ready   = ready_w & ~sel;
    assign b0.data_in     = rdata_w[15:0];
    assign b1.instr       = ins_w;
    assign b1.instr_valid = valid_w & sel;
    assign b1.mem_ready   = ready_w & sel;
    assign b1.data_in     = rdata_w;

    logic        ret0, ret1, dz0, dz1;
    logic [15:0] dbg0;
    logic [31:0] dbg1;

    cpu_multicycle_core #(.DATA_W(16), .REG_ADDR_W(4), .ADDR_W(16)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(b0), .retire(ret0), .div_zero(dz0),
        .dbg_sel(dsel[3:0]), .dbg_data(dbg0));
    cpu_multicycle_core #(.DATA_W(32), .REG_ADDR_W(5), .ADDR_W(16)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1), .retire(ret1), .div_zero(dz1),
        .dbg_sel(dsel), .dbg_data(dbg1));

    logic        c_ret, c_mem, c_dz, c_irdy;
    logic [15:0] c_pc;
    logic [31:0] c_dbg;
    assign c_ret  = sel ? ret1 : ret0;
    assign c_mem  = sel ? (b1.mem_read | b1.mem_write) : (b0.mem_read | b0.mem_write);
    assign c_dz   = sel ? dz1 : dz0;
    assign c_irdy = sel ? b1.instr_ready : b0.instr_ready;
    assign c_pc   = sel ? b1.pc : b0.pc;
    assign c_dbg  = sel ? dbg1 : {16'h0, dbg0};

    typedef struct {
        bit          s;
        logic [21:0] ins;
        logic [31:0] rd;
        int          lat;
        logic [4:0]  r;
        logic [31:0] val;
        logic [15:0] pc;
        bit          dz;
    } vec_t;

    function automatic logic [21:0] enc_r(input bit s, input int op, input int a, input int b, input int c);
        logic [3:0] o;
        logic [4:0] a5, b5, c5;
        o = op[3:0]; a5 = a[4:0]; b5 = b[4:0]; c5 = c[4:0];
        return s ? {o, a5, b5, c5, 3'b0} : {3'b0, o, a5[3:0], b5[3:0], c5[3:0], 3'b0};
    endfunction

    function automatic logic [21:0] enc_j(input bit s, input int op, input int t);
        logic [3:0]  o;
        logic [17:0] t18;
        o = op[3:0]; t18 = t[17:0];
        return s ? {o, t18} : {3'b0, o, t18[14:0]};
    endfunction

    function automatic logic [21:0] enc_b(input bit s, input int op, input int a, input int b, input int t);
        logic [3:0] o;
        logic [4:0] a5, b5;
        logic [6:0] t7;
        o = op[3:0]; a5 = a[4:0]; b5 = b[4:0]; t7 = t[6:0];
        return s ? {o, a5, b5, 1'b0, t7} : {3'b0, o, a5[3:0], b5[3:0], t7};
    endfunction

    function automatic vec_t mk(input bit s, input logic [21:0] ins, input logic [31:0] rd, input bit mem,
                                input int r, input logic [31:0] val, input logic [15:0] pc, input bit dz);
        vec_t v;
        v.s = s; v.ins = ins; v.rd = rd; v.lat = mem ? 2 : 1;
        v.r = r[4:0]; v.val = val; v.pc = pc; v.dz = dz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %0h expected %0h", cur_idx, nm, act, exp);
        end
    endtask

    // Issue one instruction, act as zero-wait memory, wait (bounded) for retire, then check state
    task automatic run(input vec_t v);
        int cyc;
        cyc = 0;
        sel = v.s; dsel = v.r;
        @(negedge clk);
        ins_w = v.ins; rdata_w = v.rd; valid_w = 1'b1;
        chk("instr_ready", 32'(c_irdy), 32'd1);
        @(posedge clk); #1 valid_w = 1'b0;
        while (!c_ret && cyc < 50) begin
            @(negedge clk); ready_w = c_mem;
            @(posedge clk); #1 cyc++;
        end
        ready_w = 1'b0;
        chk("latency", 32'(cyc), 32'(v.lat));
        chk("dbg_reg", c_dbg, v.val);
        chk("pc", 32'(c_pc), 32'(v.pc));
        chk("div_zero", 32'(c_dz), 32'(v.dz));
    endtask

    vec_t tv0[$], tv1[$];

    initial begin
        // ---- 16-bit core table ----
        tv0.push_back(mk(0, enc_r(0,10,2,0,0), 10,      1, 2, 32'd10,     16'd1, 0));
        tv0.push_back(mk(0, enc_r(0,10,3,0,0), 15,      1, 3, 32'd15,     16'd2, 0));
        tv0.push_back(mk(0, enc_r(0,0,1,2,3),  0,       0, 1, 32'd25,     16'd3, 0));
        tv0.push_back(mk(0, enc_r(0,10,2,0,0), 5,       1, 2, 32'd5,      16'd4, 0));
        tv0.push_back(mk(0, enc_r(0,10,3,0,0), 20,      1, 3, 32'd20,     16'd5, 0));
        tv0.push_back(mk(0, enc_r(0,1,1,2,3),  0,       0, 1, 32'hFFF1,   16'd6, 0));
        tv0.push_back(mk(0, enc_r(0,10,2,0,0), 300,     1, 2, 32'd300,    16'd7, 0));
        tv0.push_back(mk(0, enc_r(0,2,1,2,2),  0,       0, 1, 32'h5F90,   16'd8, 0));
        tv0.push_back(mk(0, enc_r(0,10,2,0,0), 20,      1, 2, 32'd20,     16'd9, 0));
        tv0.push_back(mk(0, enc_r(0,10,3,0,0), 4,       1, 3, 32'd4,      16'd10, 0));
        tv0.push_back(mk(0, enc_r(0,3,1,2,3),  0,       0, 1, 32'd5,      16'd11, 0));
        tv0.push_back(mk(0, enc_r(0,6,4,2,3),  0,       0, 4, 32'h4,      16'd12, 0));
        tv0.push_back(mk(0, enc_r(0,7,4,2,3),  0,       0, 4, 32'h14,     16'd13, 0));
        tv0.push_back(mk(0, enc_r(0,8,4,2,3),  0,       0, 4, 32'h10,     16'd14, 0));
        tv0.push_back(mk(0, enc_r(0,9,5,3,0),  0,       0, 5, 32'hFFFB,   16'd15, 0));
        tv0.push_back(mk(0, enc_r(0,4,5,0,0),  0,       0, 5, 32'hFFFC,   16'd16, 0));
        tv0.push_back(mk(0, enc_r(0,5,6,0,0),  0,       0, 6, 32'hFFFF,   16'd17, 0));
        tv0.push_back(mk(0, enc_r(0,10,3,0,0), 0,       1, 3, 32'd0,      16'd18, 0));
        tv0.push_back(mk(0, enc_r(0,3,1,2,3),  0,       0, 1, 32'hFFFF,   16'd19, 1));
        tv0.push_back(mk(0, enc_r(0,0,1,2,2),  0,       0, 1, 32'd40,     16'd20, 1));
        tv0.push_back(mk(0, enc_j(0,12,1),     0,       0, 1, 32'd40,     16'd1, 1));
        tv0.push_back(mk(0, enc_b(0,13,1,1,1), 0,       0, 1, 32'd40,     16'd1, 1));
        tv0.push_back(mk(0, enc_r(0,10,1,0,0), 32'hA,   1, 1, 32'hA,      16'd2, 1));
        tv0.push_back(mk(0, enc_r(0,10,2,0,0), 32'hC,   1, 2, 32'hC,      16'd3, 1));
        tv0.push_back(mk(0, enc_b(0,14,1,2,2), 0,       0, 1, 32'hA,      16'd2, 1));
        tv0.push_back(mk(0, enc_b(0,14,1,1,32'h7F), 0,  0, 1, 32'hA,      16'd3, 1));
        tv0.push_back(mk(0, enc_b(0,13,1,2,32'h40), 0,  0, 1, 32'hA,      16'd4, 1));
        tv0.push_back(mk(0, enc_j(0,12,2),     0,       0, 15, 32'd0,     16'd2, 1));
        tv0.push_back(mk(0, enc_j(0,15,3),     0,       0, 15, 32'd3,     16'd3, 1));
        tv0.push_back(mk(0, enc_j(0,12,32'h7FFF), 0,    0, 15, 32'd3,     16'h7FFF, 1));
        tv0.push_back(mk(0, enc_j(0,15,32'h7805), 0,    0, 15, 32'h8000,  16'h7805, 1));
        tv0.push_back(mk(0, enc_j(0,12,5),     0,       0, 15, 32'h8000,  16'd5, 1));
        tv0.push_back(mk(0, enc_r(0,11,0,0,1), 0,       1, 1, 32'hA,      16'd6, 1));
        // ---- 32-bit data, 32-register core table ----
        tv1.push_back(mk(1, enc_r(1,10,2,0,0), 10,      1, 2, 32'd10,     16'd1, 0));
        tv1.push_back(mk(1, enc_r(1,10,3,0,0), 15,      1, 3, 32'd15,     16'd2, 0));
        tv1.push_back(mk(1, enc_r(1,0,1,2,3),  0,       0, 1, 32'd25,     16'd3, 0));
        tv1.push_back(mk(1, enc_r(1,10,2,0,0), 5,       1, 2, 32'd5,      16'd4, 0));
        tv1.push_back(mk(1, enc_r(1,10,3,0,0), 20,      1, 3, 32'd20,     16'd5, 0));
        tv1.push_back(mk(1, enc_r(1,1,1,2,3),  0,       0, 1, 32'hFFFFFFF1, 16'd6, 0));
        tv1.push_back(mk(1, enc_r(1,10,2,0,0), 32'h10001, 1, 2, 32'h10001, 16'd7, 0));
        tv1.push_back(mk(1, enc_r(1,2,1,2,2),  0,       0, 1, 32'h00020001, 16'd8, 0));
        tv1.push_back(mk(1, enc_r(1,10,3,0,0), 0,       1, 3, 32'd0,      16'd9, 0));
        tv1.push_back(mk(1, enc_r(1,3,1,2,3),  0,       0, 1, 32'hFFFFFFFF, 16'd10, 1));
        tv1.push_back(mk(1, enc_r(1,10,4,0,0), 4,       1, 4, 32'd4,      16'd11, 1));
        tv1.push_back(mk(1, enc_r(1,3,1,2,4),  0,       0, 1, 32'h4000,   16'd12, 1));
        tv1.push_back(mk(1, enc_j(1,12,2),     0,       0, 1, 32'h4000,   16'd2, 1));
        tv1.push_back(mk(1, enc_j(1,15,3),     0,       0, 31, 32'd3,     16'd3, 1));
        tv1.push_back(mk(1, enc_j(1,12,32'h3FFFF), 0,   0, 31, 32'd3,     16'hFFFF, 1));
        tv1.push_back(mk(1, enc_j(1,15,32'h10), 0,      0, 31, 32'd0,     16'h10, 1));
        tv1.push_back(mk(1, enc_b(1,13,1,1,5), 0,       0, 1, 32'h4000,   16'd5, 1));
        tv1.push_back(mk(1, enc_b(1,14,2,3,9), 0,       0, 2, 32'h10001,  16'd9, 1));

        // ---- reset state ----
        cur_idx = 1000; dsel = 5'd1;
        #12;
        chk("rst instr_ready", 32'(b0.instr_ready), 32'd0);
        chk("rst pc", 32'(b0.pc), 32'd0);
        chk("rst strobes", 32'({b0.mem_read, b0.mem_write, ret0, dz0}), 32'd0);
        chk("rst address", 32'(b0.address), 32'd0);
        chk("rst dbg", 32'(dbg0), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        #1 chk("post-rst instr_ready", 32'(b0.instr_ready), 32'd1);

        foreach (tv0[i]) begin cur_idx = i; run(tv0[i]); end

        // ---- LOAD r7,[r1] with mem_ready low for 4 cycles (r1 = 0xA, PC = 6) ----
        cur_idx = 2000; sel = 1'b0; dsel = 5'd7;
        @(negedge clk); ins_w = enc_r(0,10,7,1,0); rdata_w = 32'h1234; valid_w = 1'b1;
        @(posedge clk); #1 valid_w = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ld wait mem_read", 32'(b0.mem_read), 32'd1);
            chk("ld wait address", 32'(b0.address), 32'hA);
            chk("ld wait no write/retire", 32'({b0.mem_write, ret0}), 32'd0);
        end
        @(negedge clk); ready_w = 1'b1;
        @(posedge clk); #1;
        chk("ld retire", 32'(ret0), 32'd1);
        chk("ld dbg r7", 32'(dbg0), 32'h1234);
        chk("ld pc", 32'(b0.pc), 32'd7);
        chk("ld strobe drop", 32'(b0.mem_read), 32'd0);
        ready_w = 1'b0;
        @(posedge clk); #1 chk("ld single retire", 32'(ret0), 32'd0);

        // ---- STORE [r1] <- r8 (0xBEEF), 3 wait cycles, then idle fetch ----
        cur_idx = 3000;
        run(mk(0, enc_r(0,10,8,0,0), 32'hBEEF, 1, 8, 32'hBEEF, 16'd8, 1));
        @(negedge clk); ins_w = enc_r(0,11,0,1,8); valid_w = 1'b1;
        @(posedge clk); #1 valid_w = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st mem_write", 32'(b0.mem_write), 32'd1);
            chk("st data_out", 32'(b0.data_out), 32'hBEEF);
            chk("st address", 32'(b0.address), 32'hA);
            chk("st no read", 32'(b0.mem_read), 32'd0);
        end
        @(negedge clk); ready_w = 1'b1;
        @(posedge clk); #1;
        chk("st retire", 32'(ret0), 32'd1);
        chk("st pc", 32'(b0.pc), 32'd9);
        chk("st strobe drop", 32'(b0.mem_write), 32'd0);
        ready_w = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("idle no retire", 32'(ret0), 32'd0);
            chk("idle instr_ready", 32'(b0.instr_ready), 32'd1);
        end

        // ---- reset asserted in the middle of a stalled LOAD ----
        cur_idx = 4000; dsel = 5'd1;
        @(negedge clk); ins_w = enc_r(0,10,9,1,0); valid_w = 1'b1;
        @(posedge clk); #1 valid_w = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre-rst mem_read", 32'(b0.mem_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid-rst mem_read", 32'(b0.mem_read), 32'd0);
        chk("mid-rst address", 32'(b0.address), 32'd0);
        chk("mid-rst pc", 32'(b0.pc), 32'd0);
        chk("mid-rst instr_ready", 32'(b0.instr_ready), 32'd0);
        chk("mid-rst dbg r1", 32'(dbg0), 32'd0);
        chk("mid-rst div_zero", 32'(dz0), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        run(mk(0, enc_r(0,10,2,0,0), 7, 1, 2, 32'd7, 16'd1, 0));
        run(mk(0, enc_r(0,0,1,2,2), 0, 0, 1, 32'd14, 16'd2, 0));
        cur_idx = 4100; dsel = 5'd9;
        #1 chk("abandoned load r9", 32'(dbg0), 32'd0);

        foreach (tv1[i]) begin cur_idx = 5000 + i; run(tv1[i]); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
